pc_redirect_fetch: RTL

- Instruction-fetch front end that consumes the branch/jump resolution result and target from execute.
- Owns the PC, issues word fetches to instruction memory over a valid/ready request channel, and buffers responses in a 2-entry FIFO feeding decode.
- On a taken redirect it reloads the PC, flushes the FIFO and discards responses still in flight.

---
 rtl/pc_redirect_fetch.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pc_redirect_fetch.sv
// Instruction-fetch front end: owns the PC, issues word fetches, pairs responses
// with their PCs in a 2-entry decode FIFO and flushes on taken redirects.
module pc_redirect_fetch #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [1:0]      i_B_J_result,
    input  logic [XLEN-1:0] i_target,
    output logic            o_imem_req_valid,
    input  logic            i_imem_req_ready,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_rsp_valid,
    input  logic [XLEN-1:0] i_imem_rsp_data,
    output logic            o_inst_valid,
    input  logic            i_inst_ready,
    output logic [XLEN-1:0] o_inst,
    output logic [XLEN-1:0] o_inst_pc,
    output logic            o_misaligned
);
    logic [XLEN-1:0] r_pc;
    logic [1:0]      r_out_cnt;
    logic [1:0]      r_drop;
    logic [XLEN-1:0] r_pcq [2];
    logic            r_pcq_wr;
    logic            r_pcq_rd;
    logic [XLEN-1:0] r_fifo_inst [2];
    logic [XLEN-1:0] r_fifo_pc   [2];
    logic            r_fifo_wr;
    logic            r_fifo_rd;
    logic [1:0]      r_fifo_cnt;
    logic            r_misaligned;

    logic            w_redirect;
    logic            w_req_ok;
    logic            w_req_fire;
    logic            w_push;
    logic            w_pop;
    logic [1:0]      w_out_next;
    logic [1:0]      w_fifo_cnt_next;
    logic            w_unused_bj;

    assign w_unused_bj = i_B_J_result[1];
    assign w_redirect  = i_B_J_result[0];

    // Outstanding requests plus buffered entries never exceed the FIFO depth,
    // so every response is guaranteed a slot.
    assign w_req_ok = (({1'b0, r_out_cnt} + {1'b0, r_fifo_cnt}) < 3'd2)
                      && (r_drop == 2'd0) && !w_redirect;
    assign o_imem_req_valid = i_rst_n && w_req_ok;
    assign o_imem_addr      = r_pc;
    assign w_req_fire       = w_req_ok && i_imem_req_ready;
    assign w_out_next       = r_out_cnt + {1'b0, w_req_fire} - {1'b0, i_imem_rsp_valid};

    assign w_push          = i_imem_rsp_valid && (r_drop == 2'd0) && !w_redirect;
    assign w_pop           = o_inst_valid && i_inst_ready && !w_redirect;
    assign w_fifo_cnt_next = r_fifo_cnt + {1'b0, w_push} - {1'b0, w_pop};

    assign o_inst_valid = (r_fifo_cnt != 2'd0);
    assign o_inst       = o_inst_valid ? r_fifo_inst[r_fifo_rd] : '0;
    assign o_inst_pc    = o_inst_valid ? r_fifo_pc[r_fifo_rd]   : '0;
    assign o_misaligned = r_misaligned;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc         <= RESET_VECTOR;
            r_out_cnt    <= 2'd0;
            r_drop       <= 2'd0;
            r_pcq_wr     <= 1'b0;
            r_pcq_rd     <= 1'b0;
            r_fifo_wr    <= 1'b0;
            r_fifo_rd    <= 1'b0;
            r_fifo_cnt   <= 2'd0;
            r_misaligned <= 1'b0;
        end else begin
            r_out_cnt    <= w_out_next;
            r_misaligned <= w_redirect && (i_target[1:0] != 2'b00);
            // The PC queue tracks every in-flight request, including ones to be dropped.
            if (w_req_fire) begin
                r_pcq_wr <= ~r_pcq_wr;
            end
            if (i_imem_rsp_valid) begin
                r_pcq_rd <= ~r_pcq_rd;
            end
            if (w_redirect) begin
                r_pc       <= {i_target[XLEN-1:2], 2'b00};
                r_drop     <= w_out_next;
                r_fifo_wr  <= 1'b0;
                r_fifo_rd  <= 1'b0;
                r_fifo_cnt <= 2'd0;
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + XLEN'(4);
                end
                if (i_imem_rsp_valid && (r_drop != 2'd0)) begin
                    r_drop <= r_drop - 2'd1;
                end
                if (w_push) begin
                    r_fifo_wr <= ~r_fifo_wr;
                end
                if (w_pop) begin
                    r_fifo_rd <= ~r_fifo_rd;
                end
                r_fifo_cnt <= w_fifo_cnt_next;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_req_fire) begin
            r_pcq[r_pcq_wr] <= r_pc;
        end
        if (w_push) begin
            r_fifo_inst[r_fifo_wr] <= i_imem_rsp_data;
            r_fifo_pc[r_fifo_wr]   <= r_pcq[r_pcq_rd];
        end
    end

endmodule
